// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers
// and returns one response per command (read data, slave error, timeout).
module apb_cmd_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_nxt;

    logic              w_cmd_ready;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic              w_rsp_err;
    logic              w_rsp_timeout;
    logic              w_psel;
    logic              w_penable;
    logic              w_pwrite;
    logic [ADDR_W-1:0] w_paddr;
    logic [DATA_W-1:0] w_pwdata;

    logic              w_cmd_hs;
    logic              w_rsp_hs;
    logic              w_timeout_hit;

    assign w_cmd_hs      = cmd_valid && cmd_ready;
    assign w_rsp_hs      = rsp_valid && rsp_ready;
    // Abort on the TIMEOUT-th ACCESS edge: earlier low edges already counted.
    assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state and next-output logic; every output holds unless changed
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_rsp_valid    = rsp_valid;
        w_rsp_rdata    = rsp_rdata;
        w_rsp_err      = rsp_err;
        w_rsp_timeout  = rsp_timeout;
        w_psel         = psel;
        w_penable      = penable;
        w_pwrite       = pwrite;
        w_paddr        = paddr;
        w_pwdata       = pwdata;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        w_state_nxt   = S_RESP;
                        w_rsp_valid   = 1'b1;
                        w_rsp_err     = 1'b1;
                        w_rsp_timeout = 1'b0;
                        w_rsp_rdata   = '0;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_psel      = 1'b1;
                        w_penable   = 1'b0;
                        w_pwrite    = cmd_write;
                        w_paddr     = cmd_addr;
                        w_pwdata    = cmd_wdata;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt    = S_ACCESS;
                w_penable      = 1'b1;
                w_wait_cnt_nxt = '0;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_state_nxt   = S_RESP;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = pslverr;
                    w_rsp_timeout = 1'b0;
                    w_rsp_rdata   = (!pwrite && !pslverr) ? prdata : '0;
                end else if (w_timeout_hit) begin
                    w_state_nxt   = S_RESP;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_rdata   = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_IDLE;
                    w_rsp_valid = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cmd_ready = (w_state_nxt == S_IDLE);
    end

    // Output registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            cmd_ready   <= w_cmd_ready;
            rsp_valid   <= w_rsp_valid;
            rsp_rdata   <= w_rsp_rdata;
            rsp_err     <= w_rsp_err;
            rsp_timeout <= w_rsp_timeout;
            psel        <= w_psel;
            penable     <= w_penable;
            pwrite      <= w_pwrite;
            paddr       <= w_paddr;
            pwdata      <= w_pwdata;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: cycle-counted bus checks plus a response scoreboard
// fed with expected results as each command is issued.
module tb_apb_cmd_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    // Slave model controls
    int          sl_waits;
    logic        sl_hang;
    logic        sl_err;
    logic [31:0] sl_rdata;
    int          sl_cnt;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_err;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u_dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave: counts low-pready ACCESS edges, becomes ready after sl_waits of them
    always @(posedge pclk) begin
        if (!(psel && penable)) sl_cnt <= 0;
        else if (!pready)       sl_cnt <= sl_cnt + 1;
    end
    assign pready  = psel && penable && !sl_hang && (sl_cnt >= sl_waits);
    assign prdata  = sl_rdata;
    assign pslverr = sl_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one command and count bus cycles until rsp_valid appears
    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input exp_t e,
                           input int exp_psel, input int exp_pen, input int exp_lat);
        int n_psel = 0;
        int n_pen  = 0;
        int lat    = 1;
        int bad    = 0;
        chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge pclk);
        cmd_valid = 1'b0;
        sb_q.push_back(e);
        while (!rsp_valid && lat < 60) begin
            if (psel) begin
                n_psel++;
                if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) bad++;
            end
            if (penable) n_pen++;
            if (cmd_ready) bad++;
            @(negedge pclk);
            lat++;
        end
        chk({tag, "_psel_cyc"}, 32'(n_psel), 32'(exp_psel));
        chk({tag, "_pen_cyc"}, 32'(n_pen), 32'(exp_pen));
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_bus_stable"}, 32'(bad), 32'd0);
    endtask

    // Compare the head of the scoreboard against the response, optionally back-pressuring
    task automatic take_rsp(input string tag, input int hold);
        exp_t e;
        int   bad = 0;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.tmo));
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            if (!rsp_valid || rsp_rdata !== e.rdata || rsp_err !== e.err ||
                rsp_timeout !== e.tmo || cmd_ready || psel) bad++;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic set_slave(input int waits, input logic hang, input logic err,
                             input logic [31:0] rdata);
        sl_waits = waits;
        sl_hang  = hang;
        sl_err   = err;
        sl_rdata = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_err     = 0;
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        set_slave(0, 1'b0, 1'b0, 32'h0);

        repeat (3) @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        presetn = 1'b1;
        @(negedge pclk);

        // Zero-wait write; slave read data must not leak into the write response
        set_slave(0, 1'b0, 1'b0, 32'hFFFF_0000);
        run_cmd("wr0", 1'b1, 32'h10, 32'hA5A5_0001, '{32'h0, 1'b0, 1'b0}, 2, 1, 3);
        take_rsp("wr0", 0);

        set_slave(3, 1'b0, 1'b0, 32'hA5A5_0001);
        run_cmd("rd3w", 1'b0, 32'h10, 32'h0, '{32'hA5A5_0001, 1'b0, 1'b0}, 5, 4, 6);
        take_rsp("rd3w", 0);

        set_slave(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        run_cmd("rderr", 1'b0, 32'h24, 32'h0, '{32'h0, 1'b1, 1'b0}, 2, 1, 3);
        take_rsp("rderr", 0);

        set_slave(0, 1'b1, 1'b0, 32'h1111_2222);
        run_cmd("tmo", 1'b0, 32'h30, 32'h0, '{32'h0, 1'b1, 1'b1}, 17, 16, 18);
        take_rsp("tmo", 0);

        // Ready on the very edge that would time out: completion wins
        set_slave(15, 1'b0, 1'b0, 32'h0000_1234);
        run_cmd("tmo_edge", 1'b0, 32'h34, 32'h0, '{32'h0000_1234, 1'b0, 1'b0}, 17, 16, 18);
        take_rsp("tmo_edge", 0);

        set_slave(0, 1'b0, 1'b0, 32'h5555_5555);
        run_cmd("misal", 1'b0, 32'h13, 32'h0, '{32'h0, 1'b1, 1'b0}, 0, 0, 1);
        take_rsp("misal", 5);

        // Reset during ACCESS: bus and response drop asynchronously, command discarded
        set_slave(0, 1'b1, 1'b0, 32'h0);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("mid_penable", 32'(penable), 32'd1);
        #2;
        presetn = 1'b0;
        #1;
        chk("async_psel", 32'(psel), 32'd0);
        chk("async_penable", 32'(penable), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        set_slave(0, 1'b0, 1'b0, 32'h0);
        @(negedge pclk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        run_cmd("wr_post", 1'b1, 32'h20, 32'h0BAD_F00D, '{32'h0, 1'b0, 1'b0}, 2, 1, 3);
        take_rsp("wr_post", 0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
